// File: rtl/bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bus_arbiter_pkg
// Purpose  : Shared encodings for the memory-bus arbiter: FSM states,
//            request type codes and default grant timeout.
// Revision : 1.0 - initial release
// ============================================================================
package bus_arbiter_pkg;

  // Arbiter FSM state encodings
  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_OFFER   = 2'd1,
    ARB_BUSY    = 2'd2,
    ARB_RELEASE = 2'd3
  } arb_state_e;

  // Request type codes presented by the handlers
  localparam logic REQ_WB  = 1'b0;
  localparam logic REQ_PWB = 1'b1;

  // Default cycles an offered grant waits for hold
  localparam int GRANT_TIMEOUT_DEF = 4;

  // Width of the offer timeout counter
  localparam int CNT_W = 4;

  // Increment an index, wrapping back to zero at n (works for any n)
  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bus_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : bus_arbiter_if
// Purpose  : Request/grant bundle between the handlers and the arbiter.
//            master = arbiter side, slave = handler side.
// Revision : 1.0 - initial release
// ============================================================================
interface bus_arbiter_if #(
  parameter int N_DEV = 4,
  parameter int IDX_W = 2
);
  logic [N_DEV-1:0] request;
  logic [N_DEV-1:0] request_type;
  logic [N_DEV-1:0] hold;
  logic [N_DEV-1:0] grant;
  logic             active;
  logic [IDX_W-1:0] owner;
  logic             owner_type;

  modport master (
    input  request, request_type, hold,
    output grant, active, owner, owner_type
  );

  modport slave (
    output request, request_type, hold,
    input  grant, active, owner, owner_type
  );
endinterface
`default_nettype wire

// File: rtl/bus_arbiter_rr_priority_picker.sv
`default_nettype none
// ============================================================================
// Module   : rr_priority_picker
// Purpose  : Combinational round-robin search: first set bit of mask_i at or
//            after ptr_i, wrapping modulo N_DEV.
// Revision : 1.0 - initial release
// ============================================================================
module rr_priority_picker #(
  parameter int N_DEV = 4,
  parameter int IDX_W = 2
) (
  input  wire logic [N_DEV-1:0] mask_i,
  input  wire logic [IDX_W-1:0] ptr_i,
  output logic                  valid_o,
  output logic [IDX_W-1:0]      idx_o
);

  // Scan from the farthest offset down so the nearest set bit wins last
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    for (int k = N_DEV - 1; k >= 0; k--) begin
      if (mask_i[(int'(ptr_i) + k) % N_DEV]) begin
        valid_o = 1'b1;
        idx_o   = IDX_W'((int'(ptr_i) + k) % N_DEV);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : bus_arbiter
// Purpose  : Grants the shared memory bus to one requester at a time.
//            Priority write-backs beat ordinary write-backs; round-robin
//            within the winning class. All outputs registered.
// Revision : 1.0 - initial release
// ============================================================================
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int N_DEV         = 4,
  parameter int IDX_W         = 2,
  parameter int GRANT_TIMEOUT = GRANT_TIMEOUT_DEF
) (
  input  wire logic       clk,
  input  wire logic       rst,
  bus_arbiter_if.master   bus
);

  localparam logic [N_DEV-1:0] ONE_HOT0 = {{(N_DEV-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(GRANT_TIMEOUT - 1);

  arb_state_e       state_q;
  logic [IDX_W-1:0] rr_ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic [N_DEV-1:0] grant_q;
  logic             active_q;
  logic [IDX_W-1:0] owner_q;
  logic             owner_type_q;

  logic [N_DEV-1:0] w_pwb;
  logic [N_DEV-1:0] w_mask;
  logic             w_win_valid;
  logic [IDX_W-1:0] w_win_idx;
  logic [IDX_W-1:0] w_owner_next;

  // Restrict the search to priority write-backs whenever any are pending
  always_comb begin
    w_pwb  = bus.request & bus.request_type;
    w_mask = (|w_pwb) ? w_pwb : bus.request;
  end

  assign w_owner_next = IDX_W'(wrap_inc(32'(owner_q), N_DEV));

  rr_priority_picker #(
    .N_DEV (N_DEV),
    .IDX_W (IDX_W)
  ) u_picker (
    .mask_i  (w_mask),
    .ptr_i   (rr_ptr_q),
    .valid_o (w_win_valid),
    .idx_o   (w_win_idx)
  );

  // Arbitration FSM with registered grant/active/owner outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ARB_IDLE;
      rr_ptr_q     <= '0;
      cnt_q        <= '0;
      grant_q      <= '0;
      active_q     <= 1'b0;
      owner_q      <= '0;
      owner_type_q <= 1'b0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (w_win_valid) begin
            owner_q      <= w_win_idx;
            owner_type_q <= bus.request_type[w_win_idx];
            grant_q      <= ONE_HOT0 << w_win_idx;
            cnt_q        <= '0;
            state_q      <= ARB_OFFER;
          end
        end
        ARB_OFFER: begin
          if (bus.hold[owner_q]) begin
            active_q <= 1'b1;
            state_q  <= ARB_BUSY;
          end else if (!bus.request[owner_q]) begin
            // Withdrawn offer does not cost the requester its turn
            grant_q <= '0;
            state_q <= ARB_IDLE;
          end else if (cnt_q == CNT_LAST) begin
            // Unclaimed offer: revoke and move the pointer past this owner
            grant_q  <= '0;
            rr_ptr_q <= w_owner_next;
            state_q  <= ARB_IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ARB_BUSY: begin
          if (!bus.hold[owner_q]) begin
            grant_q  <= '0;
            active_q <= 1'b0;
            rr_ptr_q <= w_owner_next;
            state_q  <= ARB_RELEASE;
          end
        end
        ARB_RELEASE: begin
          // One dead-bus cycle for turnaround
          state_q <= ARB_IDLE;
        end
        default: begin
          state_q <= ARB_IDLE;
        end
      endcase
    end
  end

  assign bus.grant      = grant_q;
  assign bus.active     = active_q;
  assign bus.owner      = owner_q;
  assign bus.owner_type = owner_type_q;

endmodule
`default_nettype wire
